// File: rtl/pin_uart_beacon.sv
// rtl/pin_uart_beacon.sv - self-timed UART beacon that serialises a pin-name string
// Purpose: transmits NAME as 8N1/8N2 UART characters with an internal bit-rate
//          divider and a mark-level idle gap after each frame. Frames repeat while
//          enable is high (REPEAT=1), or are sent one per start pulse (REPEAT=0).
// Optional feature: define PIN_UART_BEACON_PARITY_EN to insert an even-parity bit
//          after the data bits of every character.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   block enable; low finishes the current character, then idles
//   start      in   single-cycle frame request (REPEAT=0 only), ignored while busy
//   out        out  registered UART serial line, idle high
//   busy       out  high from the first start-bit cycle through the last gap cycle
//   frame_done out  one-cycle pulse on the final cycle of a frame
module pin_uart_beacon #(
    parameter logic [127:0] NAME      = "AF12",
    parameter int           NAME_LEN  = 4,
    parameter int           CLK_DIV   = 868,
    parameter int           STOP_BITS = 1,
    parameter int           GAP_BITS  = 10,
    parameter bit           REPEAT    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic start,
    output logic out,
    output logic busy,
    output logic frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PIN_UART_BEACON_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } state_e;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0]  IDX_LAST  = 4'(NAME_LEN - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_BITS - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  gap_q, gap_d;
    logic        out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic [7:0]  cur_char;

    assign bit_end = (div_q == DIV_LAST);

    // Character i lives at NAME[8*(NAME_LEN-1-i) +: 8]; the mask keeps the
    // elaborated (but never selected) indices beyond NAME_LEN inside NAME.
    always_comb begin
        cur_char = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i < NAME_LEN && idx_q == 4'(i)) begin
                cur_char = NAME[8*((NAME_LEN-1-i) & 15) +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            div_d = bit_end ? 16'd0 : div_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (enable && (REPEAT || start)) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 4'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 4'd7) begin
                        bit_d = 4'd0;
`ifdef PIN_UART_BEACON_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef PIN_UART_BEACON_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = 4'd0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d = 4'd0;
                        if (!enable) begin
                            // Abandoned frame: no gap, no frame_done, restart at char 0.
                            state_d = IDLE;
                            idx_d   = 4'd0;
                        end else if (idx_q != IDX_LAST) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = START;
                        end else begin
                            idx_d = 4'd0;
                            if (GAP_BITS != 0) begin
                                state_d = GAP;
                                gap_d   = 8'd0;
                            end else begin
                                done_d  = 1'b1;
                                state_d = REPEAT ? START : IDLE;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_q != GAP_LAST) begin
                        gap_d = gap_q + 8'd1;
                    end else begin
                        gap_d   = 8'd0;
                        done_d  = 1'b1;
                        // Back-to-back frames: next start bit begins on this same edge.
                        state_d = (REPEAT && enable) ? START : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so the line and status
    // lag the state register by exactly one cycle and stay glitch-free.
    always_comb begin
        out_d  = 1'b1;
        busy_d = (state_q != IDLE);
        case (state_q)
            START:  out_d = 1'b0;
            DATA:   out_d = cur_char[bit_q[2:0]];
`ifdef PIN_UART_BEACON_PARITY_EN
            PARITY: out_d = ^cur_char;
`endif
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= 16'd0;
            bit_q   <= 4'd0;
            idx_q   <= 4'd0;
            gap_q   <= 8'd0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out        = out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pin_uart_beacon.sv
// tb/tb_pin_uart_beacon.sv - self-checking bench for pin_uart_beacon
module tb_pin_uart_beacon;

`ifdef PIN_UART_BEACON_PARITY_EN
    localparam int P_BITS = 1;
`else
    localparam int P_BITS = 0;
`endif

    localparam logic [127:0] NM_R = "AF12";
    localparam logic [127:0] NM_A = "A";
    localparam int PC_R = 9 + P_BITS + 1;
    localparam int FR_R = 4 * (4 * PC_R + 2);
    localparam int FR_A = 3 * (1 * (9 + P_BITS + 2) + 0);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_r = 1'b1, en_o = 1'b1, st_o = 1'b0, en_a = 1'b0;
    logic out_r, busy_r, done_r;
    logic out_o, busy_o, done_o;
    logic out_a, busy_a, done_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pin_uart_beacon #(.NAME(NM_R), .NAME_LEN(4), .CLK_DIV(4), .STOP_BITS(1),
                      .GAP_BITS(2), .REPEAT(1'b1)) u_rep (
        .clk(clk), .rst_n(rst_n), .enable(en_r), .start(1'b0),
        .out(out_r), .busy(busy_r), .frame_done(done_r));

    pin_uart_beacon #(.NAME(NM_R), .NAME_LEN(4), .CLK_DIV(4), .STOP_BITS(1),
                      .GAP_BITS(2), .REPEAT(1'b0)) u_one (
        .clk(clk), .rst_n(rst_n), .enable(en_o), .start(st_o),
        .out(out_o), .busy(busy_o), .frame_done(done_o));

    pin_uart_beacon #(.NAME(NM_A), .NAME_LEN(1), .CLK_DIV(3), .STOP_BITS(2),
                      .GAP_BITS(0), .REPEAT(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .start(1'b0),
        .out(out_a), .busy(busy_a), .frame_done(done_a));

    // Expected serial level at output position pos (0 = first start-bit cycle).
    function automatic logic exp_bit(input logic [127:0] nm, input int len, input int div,
                                     input int stopb, input int gap, input int pos);
        int per_char, frame, slot, c, b;
        logic [7:0] ch;
        per_char = 9 + P_BITS + stopb;
        frame    = div * (len * per_char + gap);
        slot     = (pos % frame) / div;
        if (slot >= len * per_char) return 1'b1;
        c  = slot / per_char;
        b  = slot % per_char;
        ch = nm[8*(len-1-c) +: 8];
        if (b == 0) return 1'b0;
        if (b <= 8) return ch[b-1];
        if (P_BITS == 1 && b == 9) return ^ch;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %b want %b", tag, k, act, exp);
        end
    endtask

    // k = negedges since the edge that sampled the trigger.
    task automatic chk_r(input int k);
        if (k == 0) begin
            chk("rep_out", k, out_r, 1'b1);
            chk("rep_busy", k, busy_r, 1'b0);
            chk("rep_done", k, done_r, 1'b0);
        end else begin
            chk("rep_out", k, out_r, exp_bit(NM_R, 4, 4, 1, 2, k - 1));
            chk("rep_busy", k, busy_r, 1'b1);
            chk("rep_done", k, done_r, ((k - 1) % FR_R) == FR_R - 1);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic en;
        logic st;
        int   cyc;
        logic e_out;
        logic e_busy;
        logic e_done;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // One-shot vectors: each row drives en/start (start for one edge only),
        // advances cyc clocks, then compares outputs at the following negedge.
        vecs[0]  = '{1'b1, 1'b1, 1,         1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1,         1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4,         1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4,         1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 20,        1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 4,         1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, FR_R - 33, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1,         1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 40,        1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3,         1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2,         1'b0, 1'b1, 1'b0};

        // Reset held with enable high.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_out", i, out_r, 1'b1);
            chk("rst_busy", i, busy_r, 1'b0);
            chk("rst_done", i, done_r, 1'b0);
        end
        rst_n = 1'b1;

        // Free-running decode over two frames and a bit.
        for (int k = 0; k <= 2 * FR_R + 2; k++) begin
            @(negedge clk);
            chk_r(k);
        end

        // Enable drop during data bit 3 of character 2.
        reset_pulse();
        begin
            int k_drop, k_end;
            k_drop = 4 * (2 * PC_R + 4) + 2;
            k_end  = 4 * 3 * PC_R;
            for (int k = 0; k <= k_end + 30; k++) begin
                @(negedge clk);
                if (k <= k_end) begin
                    chk_r(k);
                end else begin
                    chk("drop_out", k, out_r, 1'b1);
                    chk("drop_busy", k, busy_r, 1'b0);
                    chk("drop_done", k, done_r, 1'b0);
                end
                if (k == k_drop) en_r = 1'b0;
            end
        end
        en_r = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            chk_r(k);
        end

        // Asynchronous reset in the middle of a data bit (line low there).
        reset_pulse();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk_r(k);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 0, out_r, 1'b1);
        chk("arst_busy", 0, busy_r, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            chk_r(k);
        end

        // One-shot table.
        for (int v = 0; v < 11; v++) begin
            en_o = vecs[v].en;
            st_o = vecs[v].st;
            @(posedge clk);
            #1 st_o = 1'b0;
            @(negedge clk);
            for (int c = 1; c < vecs[v].cyc; c++) @(negedge clk);
            chk($sformatf("one_out[%0d]", v), v, out_o, vecs[v].e_out);
            chk($sformatf("one_busy[%0d]", v), v, busy_o, vecs[v].e_busy);
            chk($sformatf("one_done[%0d]", v), v, done_o, vecs[v].e_done);
        end

        // Single character, two stop bits, zero gap.
        en_a = 1'b1;
        for (int k = 0; k <= 3 * FR_A + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("a_out", k, out_a, 1'b1);
                chk("a_busy", k, busy_a, 1'b0);
                chk("a_done", k, done_a, 1'b0);
            end else begin
                chk("a_out", k, out_a, exp_bit(NM_A, 1, 3, 2, 0, k - 1));
                chk("a_busy", k, busy_a, 1'b1);
                chk("a_done", k, done_a, ((k - 1) % FR_A) == FR_A - 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
